// File: rtl/tape_head_unit_pkg.sv
// Shared encodings for the tape head unit: command ops, head moves, FSM states, blank symbol.
package tape_head_unit_pkg;

    localparam int unsigned OP_W = 2;
    localparam int unsigned MV_W = 2;

    localparam logic [OP_W-1:0] OP_READ  = 2'b00;
    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
    localparam logic [OP_W-1:0] OP_CLEAR = 2'b10;
    localparam logic [OP_W-1:0] OP_HOME  = 2'b11;

    localparam logic [MV_W-1:0] MV_STAY  = 2'b00;
    localparam logic [MV_W-1:0] MV_RIGHT = 2'b01;
    localparam logic [MV_W-1:0] MV_LEFT  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } state_t;

    // Blank symbol: only the MSB of a w-bit symbol set.
    function automatic logic [31:0] blank_sym(input int unsigned w);
        return 32'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/tape_head_unit_cell_bank.sv
// tape_cell_bank: DEPTH x SYM_W tape storage, one write port, combinational read port.
module tape_cell_bank
    import tape_head_unit_pkg::*;
#(
    parameter  int unsigned SYM_W  = 2,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned HEAD_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [HEAD_W-1:0] i_waddr,
    input  logic [SYM_W-1:0]  i_wdata,
    input  logic [HEAD_W-1:0] i_raddr,
    output logic [SYM_W-1:0]  o_rdata
);

    localparam logic [SYM_W-1:0] BLANK = SYM_W'(blank_sym(SYM_W));

    logic [SYM_W-1:0] r_cells [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_cells[i] <= BLANK;
            end
        end else if (i_we) begin
            r_cells[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_cells[i_raddr];

endmodule

// File: rtl/tape_head_unit.sv
// Turing-machine tape with internal head pointer, command handshake and multi-cycle CLEAR sweep.
// Define TAPE_WRAP_EN to make head moves wrap at the tape ends (edge_err then never pulses).
module tape_head_unit
    import tape_head_unit_pkg::*;
#(
    parameter  int unsigned SYM_W    = 2,
    parameter  int unsigned DEPTH    = 8,
    parameter  int unsigned HOME_POS = 0,
    localparam int unsigned HEAD_W   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [OP_W-1:0]   i_cmd_op,
    input  logic [SYM_W-1:0]  i_cmd_sym,
    input  logic [MV_W-1:0]   i_cmd_move,
    output logic              o_rd_valid,
    output logic [SYM_W-1:0]  o_rd_sym,
    output logic [HEAD_W-1:0] o_head,
    output logic              o_edge_err,
    output logic              o_busy
);

    localparam logic [SYM_W-1:0]  BLANK  = SYM_W'(blank_sym(SYM_W));
    localparam logic [HEAD_W-1:0] HOME_H = HEAD_W'(HOME_POS);
    localparam logic [HEAD_W-1:0] LAST_H = HEAD_W'(DEPTH - 1);

    state_t            r_state;
    logic [HEAD_W-1:0] r_head;
    logic [HEAD_W-1:0] r_idx;
    logic [SYM_W-1:0]  r_rd_sym;
    logic              r_rd_valid;
    logic              r_edge_err;
    logic              r_busy;
    logic              r_cmd_ready;

    logic              w_accept;
    logic [HEAD_W-1:0] w_head_mv;
    logic              w_edge_hit;
    logic              w_we;
    logic [HEAD_W-1:0] w_waddr;
    logic [SYM_W-1:0]  w_wdata;
    logic [SYM_W-1:0]  w_cell_rd;

    assign w_accept = i_cmd_valid & r_cmd_ready;

    // Head after the requested move; ends are compared explicitly so any DEPTH works.
    always_comb begin
        w_head_mv  = r_head;
        w_edge_hit = 1'b0;
        case (i_cmd_move)
            MV_RIGHT: begin
                if (r_head == LAST_H) begin
`ifdef TAPE_WRAP_EN
                    w_head_mv = '0;
`else
                    w_edge_hit = 1'b1;
`endif
                end else begin
                    w_head_mv = r_head + HEAD_W'(1);
                end
            end
            MV_LEFT: begin
                if (r_head == '0) begin
`ifdef TAPE_WRAP_EN
                    w_head_mv = LAST_H;
`else
                    w_edge_hit = 1'b1;
`endif
                end else begin
                    w_head_mv = r_head - HEAD_W'(1);
                end
            end
            default: ;
        endcase
    end

    // The sweep owns the write port while clearing; otherwise WRITE uses the pre-move head.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_head;
        w_wdata = i_cmd_sym;
        if (r_state == ST_CLR) begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdata = BLANK;
        end else if (w_accept && (i_cmd_op == OP_WRITE)) begin
            w_we = 1'b1;
        end
    end

    tape_cell_bank #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH)
    ) u_cells (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_head),
        .o_rdata (w_cell_rd)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_head      <= HOME_H;
            r_idx       <= '0;
            r_rd_sym    <= BLANK;
            r_rd_valid  <= 1'b0;
            r_edge_err  <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
            r_edge_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (i_cmd_op)
                            OP_READ: begin
                                r_rd_sym   <= w_cell_rd;
                                r_rd_valid <= 1'b1;
                                r_head     <= w_head_mv;
                                r_edge_err <= w_edge_hit;
                            end
                            OP_WRITE: begin
                                r_head     <= w_head_mv;
                                r_edge_err <= w_edge_hit;
                            end
                            OP_CLEAR: begin
                                r_state     <= ST_CLR;
                                r_idx       <= '0;
                                r_busy      <= 1'b1;
                                r_cmd_ready <= 1'b0;
                            end
                            OP_HOME: r_head <= HOME_H;
                        endcase
                    end
                end
                ST_CLR: begin
                    if (r_idx == LAST_H) begin
                        r_state     <= ST_IDLE;
                        r_head      <= HOME_H;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_idx <= r_idx + HEAD_W'(1);
                    end
                end
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_sym    = r_rd_sym;
    assign o_head      = r_head;
    assign o_edge_err  = r_edge_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_tape_head_unit.sv
// Directed bench for tape_head_unit: an 8x2 default instance and a 5x3 instance (odd depth).
module tb_tape_head_unit;
    import tape_head_unit_pkg::*;

`ifdef TAPE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       v8, rdy8, rdv8, edge8, busy8;
    logic [1:0] op8, sym8, mv8, rds8;
    logic [2:0] head8;

    logic       v5, rdy5, rdv5, edge5, busy5;
    logic [1:0] op5, mv5;
    logic [2:0] sym5, rds5, head5;

    int checks = 0;
    int errors = 0;
    int cnt;

    tape_head_unit u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(v8), .o_cmd_ready(rdy8),
        .i_cmd_op(op8), .i_cmd_sym(sym8), .i_cmd_move(mv8), .o_rd_valid(rdv8),
        .o_rd_sym(rds8), .o_head(head8), .o_edge_err(edge8), .o_busy(busy8)
    );

    tape_head_unit #(.SYM_W(3), .DEPTH(5), .HOME_POS(0)) u_dut5 (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(v5), .o_cmd_ready(rdy5),
        .i_cmd_op(op5), .i_cmd_sym(sym5), .i_cmd_move(mv5), .o_rd_valid(rdv5),
        .o_rd_sym(rds5), .o_head(head5), .o_edge_err(edge5), .o_busy(busy5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd8(input logic [1:0] op, input logic [1:0] sym, input logic [1:0] mv);
        v8 = 1'b1; op8 = op; sym8 = sym; mv8 = mv;
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic cmd5(input logic [1:0] op, input logic [2:0] sym, input logic [1:0] mv);
        v5 = 1'b1; op5 = op; sym5 = sym; mv5 = mv;
        @(posedge clk); #1;
        v5 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v8 = 1'b0; op8 = OP_READ; sym8 = '0; mv8 = MV_STAY;
        v5 = 1'b0; op5 = OP_READ; sym5 = '0; mv5 = MV_STAY;
        #12;
        chk("rst_head", head8, 3'd0);
        chk("rst_rd_sym", rds8, 2'b10);
        chk("rst_rd_valid", rdv8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_edge", edge8, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_ready", rdy8, 1'b1);

        // Read every blank cell moving right; the last move hits the right end.
        for (int i = 0; i < 8; i++) begin
            cmd8(OP_READ, 2'b00, MV_RIGHT);
            chk("t1_rd_sym", rds8, 2'b10);
            chk("t1_rd_valid", rdv8, 1'b1);
            chk("t1_head", head8, (i < 7) ? 32'(i + 1) : (WRAP ? 32'd0 : 32'd7));
            chk("t1_edge", edge8, (i == 7 && !WRAP) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        chk("idle_rd_valid", rdv8, 1'b0);
        chk("idle_edge", edge8, 1'b0);
        chk("idle_head", head8, WRAP ? 3'd0 : 3'd7);

        cmd8(OP_HOME, 2'b01, MV_RIGHT);
        chk("home_head", head8, 3'd0);

        cmd8(OP_WRITE, 2'b01, MV_RIGHT);
        chk("t2_w1_head", head8, 3'd1);
        chk("t2_w1_rdv", rdv8, 1'b0);
        cmd8(OP_WRITE, 2'b00, MV_RIGHT);
        chk("t2_w2_head", head8, 3'd2);
        cmd8(OP_HOME, 2'b11, MV_LEFT);
        chk("t2_home", head8, 3'd0);
        cmd8(OP_READ, 2'b00, MV_RIGHT);
        chk("t2_r1_sym", rds8, 2'b01);
        chk("t2_r1_head", head8, 3'd1);
        cmd8(OP_READ, 2'b00, MV_RIGHT);
        chk("t2_r2_sym", rds8, 2'b00);
        chk("t2_r2_head", head8, 3'd2);

        // Left move at the left end.
        cmd8(OP_HOME, 2'b00, MV_STAY);
        cmd8(OP_READ, 2'b00, MV_LEFT);
        chk("t3_left_sym", rds8, 2'b01);
        chk("t3_left_head", head8, WRAP ? 3'd7 : 3'd0);
        chk("t3_left_edge", edge8, WRAP ? 1'b0 : 1'b1);
        cmd8(OP_HOME, 2'b00, MV_STAY);

        cmd8(OP_WRITE, 2'b11, 2'b11);
        chk("stay11_head", head8, 3'd0);
        cmd8(OP_READ, 2'b00, MV_STAY);
        chk("stay_rd_sym", rds8, 2'b11);
        chk("stay_head", head8, 3'd0);

        // CLEAR from head 3 while a WRITE is held on the bus the whole sweep.
        for (int i = 0; i < 3; i++) cmd8(OP_READ, 2'b00, MV_RIGHT);
        cmd8(OP_CLEAR, 2'b00, MV_RIGHT);
        chk("clr_ready", rdy8, 1'b0);
        chk("clr_busy", busy8, 1'b1);
        chk("clr_head", head8, 3'd3);
        v8 = 1'b1; op8 = OP_WRITE; sym8 = 2'b01; mv8 = MV_RIGHT;
        cnt = busy8 ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy8) break;
            chk("clr_ready_low", rdy8, 1'b0);
            @(posedge clk); #1;
            if (busy8) cnt++;
        end
        v8 = 1'b0;
        chk("clr_cycles", cnt, 8);
        chk("clr_done_busy", busy8, 1'b0);
        chk("clr_done_ready", rdy8, 1'b1);
        chk("clr_done_head", head8, 3'd0);
        for (int i = 0; i < 8; i++) begin
            cmd8(OP_READ, 2'b00, MV_RIGHT);
            chk("clr_cell_blank", rds8, 2'b10);
        end
        cmd8(OP_HOME, 2'b00, MV_STAY);

        // Reset three cycles into a CLEAR; a READ held through release is taken at once.
        cmd8(OP_WRITE, 2'b01, MV_RIGHT);
        chk("t5_head_pre", head8, 3'd1);
        cmd8(OP_CLEAR, 2'b00, MV_STAY);
        repeat (2) begin @(posedge clk); #1; end
        chk("t5_busy_mid", busy8, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_head", head8, 3'd0);
        chk("t5_rst_busy", busy8, 1'b0);
        v8 = 1'b1; op8 = OP_READ; sym8 = 2'b00; mv8 = MV_RIGHT;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        v8 = 1'b0;
        chk("t5_first_rdv", rdv8, 1'b1);
        chk("t5_first_sym", rds8, 2'b10);
        chk("t5_first_head", head8, 3'd1);

        // Odd depth, 3-bit symbols.
        cmd5(OP_READ, 3'b000, MV_LEFT);
        chk("t6_left_sym", rds5, 3'b100);
        chk("t6_left_head", head5, WRAP ? 3'd4 : 3'd0);
        chk("t6_left_edge", edge5, WRAP ? 1'b0 : 1'b1);
        cmd5(OP_WRITE, 3'b011, MV_STAY);
        cmd5(OP_READ, 3'b000, MV_STAY);
        chk("t6_rd_sym", rds5, 3'b011);
        cmd5(OP_READ, 3'b000, MV_RIGHT);
        chk("t6_right_head", head5, WRAP ? 3'd0 : 3'd1);
        chk("t6_right_edge", edge5, 1'b0);
        cmd5(OP_CLEAR, 3'b000, MV_STAY);
        cnt = busy5 ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy5) break;
            @(posedge clk); #1;
            if (busy5) cnt++;
        end
        chk("t6_clr_cycles", cnt, 5);
        chk("t6_clr_ready", rdy5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cmd5(OP_READ, 3'b000, MV_RIGHT);
            chk("t6_cell_blank", rds5, 3'b100);
        end
        chk("t6_end_head", head5, WRAP ? 3'd0 : 3'd4);
        chk("t6_end_edge", edge5, WRAP ? 1'b0 : 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
